// File: rtl/mio_responder.sv
// Memory/IO responder: single-request CPU bus slave in front of a word RAM,
// an LED register, a free-running timer and a synchronized switch input.
module mio_responder #(
  parameter int RAM_WAIT = 2,
  parameter int RAM_AW   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] Addr_in,
  input  logic [31:0] Data_in,
  output logic [31:0] Data_out,
  output logic        MIO_ready,
  input  logic [15:0] sw,
  output logic [15:0] led
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Wait counter counts RAM_WAIT-1 down to 0, giving RAM_WAIT cycles in WAIT.
  localparam logic [3:0]  WAIT_LD = (RAM_WAIT > 0) ? 4'(RAM_WAIT - 1) : 4'd0;
  // IO registers are decoded on the word address (byte offset bits dropped).
  localparam logic [29:0] IO_LED  = 30'h3C00_0000;
  localparam logic [29:0] IO_TMR  = 30'h3C00_0001;

  state_t              state, state_nxt;
  logic [3:0]          wait_cnt;
  logic [29:0]         req_word;
  logic                req_w;
  logic [31:0]         req_data;
  logic [15:0]         sw_meta, sw_sync;
  logic [31:0]         timer;
  logic [31:0]         ram_q;
  logic [31:0]         rd_mux;
  logic [RAM_AW-1:0]   rd_idx;
  logic                in_io, req_io, wr;
  logic [31:0]         mem [2**RAM_AW];

  // Byte offset within a word carries no meaning for this block.
  logic unused_addr_bits;
  assign unused_addr_bits = ^Addr_in[1:0];

  assign in_io  = (Addr_in[31:28] == 4'hF);
  assign req_io = (req_word[29:26] == 4'hF);
  assign wr     = (state == RESP) && req_w;

  // In IDLE the RAM is addressed straight from the bus so a zero-wait read
  // has its data registered in time for the very next (RESP) cycle.
  assign rd_idx = (state == IDLE) ? Addr_in[RAM_AW+1:2] : req_word[RAM_AW-1:0];

  // Next-state logic for the request handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (CPU_MIO) state_nxt = (!in_io && RAM_WAIT > 0) ? WAIT : RESP;
      WAIT: if (wait_cnt == 4'd0) state_nxt = RESP;
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read-data selection and bus outputs; Data_out is forced to 0 outside RESP.
  always_comb begin
    rd_mux = 32'h0;
    if (!req_io)                 rd_mux = ram_q;
    else if (req_word == IO_LED) rd_mux = {16'h0, sw_sync};
    else if (req_word == IO_TMR) rd_mux = timer;
    MIO_ready = (state == RESP);
    Data_out  = ((state == RESP) && !req_w) ? rd_mux : 32'h0;
  end

  // State register, wait counter and request capture (captured only in IDLE).
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      req_word <= 30'h0;
      req_w    <= 1'b0;
      req_data <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && CPU_MIO) begin
        req_word <= Addr_in[31:2];
        req_w    <= mem_w;
        req_data <= Data_in;
        wait_cnt <= WAIT_LD;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sw_meta <= 16'h0;
      sw_sync <= 16'h0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  // LED register, written at the end of a RESP cycle.
  always_ff @(posedge clk) begin
    if (!reset)                         led <= 16'h0;
    else if (wr && req_word == IO_LED)  led <= req_data[15:0];
  end

  // Free-running timer; a CPU write takes priority over the increment.
  always_ff @(posedge clk) begin
    if (!reset)                         timer <= 32'h0;
    else if (wr && req_word == IO_TMR)  timer <= req_data;
    else                                timer <= timer + 32'd1;
  end

  // Word RAM: one write port used in RESP, registered read every cycle.
  // Contents are not cleared by reset; a write in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset && wr && !req_io) mem[req_word[RAM_AW-1:0]] <= req_data;
    ram_q <= mem[rd_idx];
  end

endmodule
